// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory request/response bus between fetch stage and imem
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, redirect select, IF/ID pipeline register
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_stage_if.master       imem,
    input  logic                stall,
    input  logic                flush,
    input  logic                branch_taken,
    input  logic [31:0]         branch_target,
    input  logic                jump,
    input  logic [25:0]         jump_target,
    input  logic                jump_reg,
    input  logic [31:0]         jump_reg_addr,
    output logic [31:0]         pc,
    output logic [31:0]         if_id_instruct,
    output logic [31:0]         if_id_pc4,
    output logic                if_id_valid
);

    typedef enum logic {
        BOOT  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        req;
    logic        redirect;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        fetching;

    // State register; reset parks the stage in BOOT for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and request decode; FETCH is absorbing until reset.
    always_comb begin
        state_next = state;
        req        = 1'b0;
        case (state)
            BOOT: begin
                state_next = FETCH;
            end
            FETCH: begin
                req = 1'b1;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;
    assign pc_plus4       = pc + 32'd4;
    assign fetching       = (state == FETCH);

    // Redirect target select: jump_reg beats jump beats branch; targets are word aligned.
    always_comb begin
        redirect   = jump_reg | jump | branch_taken;
        target_raw = branch_target;
        if (jump_reg) begin
            target_raw = jump_reg_addr;
        end else if (jump) begin
            target_raw = {if_id_pc4[31:28], jump_target, 2'b00};
        end
        target = target_raw & 32'hFFFF_FFFC;
    end

    // PC and IF/ID update; a redirect squashes the word in flight regardless of stall/ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_PC;
            if_id_instruct <= NOP_WORD;
            if_id_pc4      <= 32'h0;
            if_id_valid    <= 1'b0;
        end else if (fetching) begin
            if (redirect) begin
                pc             <= target;
                if_id_instruct <= NOP_WORD;
                if_id_valid    <= 1'b0;
            end else begin
                if (!stall && imem.imem_ready) begin
                    pc <= pc_plus4;
                end
                if (flush || (!stall && !imem.imem_ready)) begin
                    if_id_instruct <= NOP_WORD;
                    if_id_valid    <= 1'b0;
                end else if (!stall) begin
                    if_id_instruct <= imem.imem_rdata;
                    if_id_pc4      <= pc_plus4;
                    if_id_valid    <= 1'b1;
                end
            end
        end
    end

endmodule
